// File: rtl/one_byte_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : one_byte_uart_rx
//  Description : Single-byte UART receiver (8N1, LSB first, idle-high line).
//                Samples the asynchronous serial input at mid-bit, presents
//                one byte with a one-clock done strobe, and flags a framing
//                error when the stop bit samples low.
//  Optional    : `define UART_RX_PARITY_EN to add an even-parity bit between
//                the data bits and the stop bit, and the parity_err output.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - asynchronous active-low reset
//                rx_in      - serial line, asynchronous to clk, idle high
//                rx_data    - last correctly framed byte (held)
//                rx_done    - one-clock pulse when rx_data is updated
//                frame_err  - one-clock pulse when the stop bit samples 0
//                parity_err - (parity build only) pulses with rx_done when
//                             data XOR parity is 1
//                busy       - high whenever the receiver is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module one_byte_uart_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam logic [15:0] C_HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] C_FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_done;
    logic        r_frame_err;

    logic        w_start_edge;
    logic        w_cnt_clr;
    logic        w_bit_tick;
    logic        w_stop_ok;
    logic        w_stop_bad;

    // r_sync2 is the synchronized line; r_prev is one clock older.
    assign w_start_edge = r_prev & ~r_sync2;

`ifdef UART_RX_PARITY_EN
    logic        r_par_bit;
    logic        r_parity_err;
    logic        w_par_tick;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_bit_tick   = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_tick   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_next = S_START;
                    w_cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                // Mid start bit: a high line here means the edge was a glitch.
                if (r_baud_cnt == C_HALF_M1) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_baud_cnt == C_FULL_M1) begin
                    w_cnt_clr  = 1'b1;
                    w_bit_tick = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_baud_cnt == C_FULL_M1) begin
                    w_cnt_clr    = 1'b1;
                    w_par_tick   = 1'b1;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaving mid stop bit lets a back-to-back start edge be caught.
                if (r_baud_cnt == C_FULL_M1) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = S_IDLE;
                    w_stop_ok    = r_sync2;
                    w_stop_bad   = ~r_sync2;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_prev      <= 1'b1;
            r_state     <= S_IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_next;

            if (r_state == S_IDLE || w_cnt_clr) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end

            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_bit_tick) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_bit_tick) begin
                r_shift[r_bit_cnt] <= r_sync2;
            end

            r_rx_done   <= w_stop_ok;
            r_frame_err <= w_stop_bad;
            if (w_stop_ok) begin
                r_rx_data <= r_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits XOR parity bit must be 0. Only reported on a
    // well-framed byte, so a framing error hides any parity complaint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_tick) begin
                r_par_bit <= r_sync2;
            end
            r_parity_err <= w_stop_ok & ((^r_shift) ^ r_par_bit);
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/one_byte_uart_rx.md
Name: one_byte_uart_rx

Overview:
- Single-byte UART receiver; the counterpart to the team's one-byte UART transmitter.
- Frame format: 8N1, LSB first, line idles high.
- Samples the asynchronous serial line in the middle of each bit and presents one byte with a one-cycle done strobe.
- Sits between the board RX pin and byte-level consumers, for example loopback tests against the transmitter.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434), clocks per bit. Overridable; benches use 16. Legal range 4..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_in  in  1  serial line, asynchronous to clk, idle high.
- rx_data  out  8  last correctly framed byte; held until the next good frame.
- rx_done  out  1  one-clock pulse when rx_data is updated.
- frame_err  out  1  one-clock pulse when the stop bit samples 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - rx_data = 8'h00; rx_done, frame_err, busy = 0.
  - Synchronizer flops = 1; state = IDLE; baud counter and bit counter = 0.
  - Reset asserted mid-frame aborts the frame immediately with no strobe. After release, the block waits for a fresh falling edge.
- Input conditioning:
  - rx_in passes through a 2-flop synchronizer to give rx_sync.
  - A third flop gives rx_prev.
  - Start edge = rx_prev==1 && rx_sync==0.
- Baud counter:
  - 16 bits, cleared on every state entry.
  - Counts only outside IDLE; not free-running.
- States:
  - IDLE: busy=0. On start edge, go to START and clear the counter.
  - START: when counter == CLKS_PER_BIT/2 - 1 (integer divide), sample rx_sync. If 0, go to DATA with counter cleared. If 1 (false start / glitch), return to IDLE with no strobe.
  - DATA: when counter == CLKS_PER_BIT - 1, sample rx_sync into shift[bit_cnt], with bit 0 first, then increment bit_cnt. After bit 7 (bit_cnt 0..7), go to STOP.
  - STOP: when counter == CLKS_PER_BIT - 1, sample rx_sync.
    - If 1: rx_data <= shift register; rx_done=1 the next cycle.
    - If 0: frame_err=1 the next cycle; rx_data unchanged.
    - In both cases, return to IDLE.
- Latency: the stop sample falls 9.5 bit periods after the synchronized start edge; the strobe follows 1 clock later. The synchronizer adds 2 clocks of offset from the raw edge.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start bit directly after the stop bit is caught with no gap required.
- Break or held-low line: after frame_err, the line must return high and fall again before a new frame starts. No retrigger occurs while it stays low.
- rx_done and frame_err are never high in the same cycle. Neither is ever high for more than 1 clock.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - The frame becomes start, 8 data, even parity, stop.
  - A PARITY state sits between DATA and STOP and samples at mid-bit.
  - Extra output port parity_err (1 bit, reset 0) pulses in the same cycle as rx_done when the XOR of the data bits and the parity bit is 1.
  - rx_data is still updated on a parity error.
  - A frame error suppresses parity_err.
- When undefined: 8N1 only; no parity_err port and no PARITY state.

Test Plan:
- CLKS_PER_BIT=16; drive frame 0x55 (8N1) -> exactly one rx_done pulse; rx_data=8'h55; frame_err=0; busy falls in the same cycle as the strobe.
- Frames 0xA3 then 0x0F with zero idle between them -> two rx_done pulses 160±2 clocks apart; rx_data=8'hA3, then 8'h0F.
- rx_in low for 3 clocks, then high -> START aborts at mid-bit; no rx_done or frame_err; busy returns to 0 within 9 clocks.
- Frame 0x3C with stop bit driven 0 -> frame_err pulse; no rx_done; rx_data keeps its previous value. Line held low 40 bit-times, then 0x81 sent -> only 0x81 received.
- rst_n pulsed low mid-data of 0xFF, then 0x12 sent -> no strobe for the aborted frame; rx_data=8'h12 after the second frame.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> rx_done, parity_err=0. 0x07 with parity 0 -> rx_done and parity_err=1 in the same cycle; rx_data=8'h07.
